// File: rtl/wb_result_stage.sv
// wb_result_stage: write-back source select, load extract and one-cycle rf write; WB_BYPASS_EN lets COMMIT accept the next instruction
module wb_result_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_result_sel,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic [XLEN-1:0]       in_pc_plus4,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [2:0]            in_funct3,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic                  mem_rsp_valid,
    input  logic [XLEN-1:0]       mem_rsp_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  busy
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_MEM = 2'd1;
    localparam logic [1:0] COMMIT   = 2'd2;
    logic [1:0]            state_q, state_d;
    logic [1:0]            offset_q, offset_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  reg_write_q, reg_write_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
    logic                  accept, load_done;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [XLEN-1:0]       load_val, direct_val;
    always_comb begin
`ifdef WB_BYPASS_EN
        in_ready = state_q == IDLE || state_q == COMMIT;
`else
        in_ready = state_q == IDLE;
`endif
        accept    = in_valid && in_ready;
        load_done = state_q == WAIT_MEM && mem_rsp_valid;
        state_d   = accept ? (in_result_sel == 2'b01 ? WAIT_MEM : COMMIT)
                  : state_q == WAIT_MEM ? (mem_rsp_valid ? COMMIT : WAIT_MEM) : IDLE;
        offset_d    = accept ? in_alu_result[1:0] : offset_q;
        funct3_d    = accept ? in_funct3 : funct3_q;
        rd_d        = accept ? in_rd : rd_q;
        reg_write_d = accept ? in_reg_write : reg_write_q;
        byte_sel = mem_rsp_data[{offset_q, 3'b000} +: 8];
        half_sel = offset_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
        load_val = funct3_q[1:0] == 2'b00 ? {{(XLEN-8){~funct3_q[2] & byte_sel[7]}}, byte_sel}
                 : funct3_q[1:0] == 2'b01 ? {{(XLEN-16){~funct3_q[2] & half_sel[15]}}, half_sel}
                 : mem_rsp_data;
        direct_val = in_result_sel == 2'b00 ? in_alu_result
                   : in_result_sel == 2'b10 ? in_pc_plus4 : in_imm;
        // address/data only move on an actual write so the rf sees stable values otherwise
        rf_we_d    = (accept && in_result_sel != 2'b01) ? (in_reg_write && in_rd != '0)
                   : load_done ? (reg_write_q && rd_q != '0) : 1'b0;
        rf_waddr_d = rf_we_d ? (load_done ? rd_q : in_rd) : rf_waddr_q;
        rf_wdata_d = rf_we_d ? (load_done ? load_val : direct_val) : rf_wdata_q;
        rf_we    = rf_we_q;
        rf_waddr = rf_waddr_q;
        rf_wdata = rf_wdata_q;
        busy     = state_q != IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            offset_q    <= '0;
            funct3_q    <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end
endmodule

// File: tb/tb_wb_result_stage.sv
// tb_wb_result_stage: randomized self-checking bench for wb_result_stage against an arithmetic reference model
module tb_wb_result_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_result_sel = '0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_pc_plus4 = '0;
    logic [31:0] in_imm = '0;
    logic [2:0]  in_funct3 = '0;
    logic [4:0]  in_rd = '0;
    logic        in_reg_write = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    logic [4:0]  last_a = '0;
    logic [31:0] last_d = '0;
`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    wb_result_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_result_sel(in_result_sel), .in_alu_result(in_alu_result),
        .in_pc_plus4(in_pc_plus4), .in_imm(in_imm), .in_funct3(in_funct3),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] load_model(input logic [2:0] f, input logic [1:0] off, input logic [31:0] w);
        int unsigned u;
        int          v;
        case (f)
            3'b000, 3'b100: begin
                u = (w / (32'd1 << (8 * off))) % 256;
                v = (f == 3'b000 && u >= 128) ? int'(u) - 256 : int'(u);
            end
            3'b001, 3'b101: begin
                u = off >= 2 ? w / 65536 : w % 65536;
                v = (f == 3'b001 && u >= 32768) ? int'(u) - 65536 : int'(u);
            end
            default: v = int'(w);
        endcase
        return 32'(v);
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s wait_ready: in_ready=%b required 1 within 10 cycles", name, in_ready);
        end
    endtask

    task automatic check_write(input string name, input logic exp_we, input logic [4:0] rd, input logic [31:0] val);
        checks++;
        if (rf_we !== exp_we) begin
            errors++;
            $display("FAIL %s rf_we: got %b required %b", name, rf_we, exp_we);
        end
        if (exp_we) begin
            last_a = rd;
            last_d = val;
        end
        checks++;
        if (rf_waddr !== last_a) begin
            errors++;
            $display("FAIL %s rf_waddr: got %0d required %0d", name, rf_waddr, last_a);
        end
        checks++;
        if (rf_wdata !== last_d) begin
            errors++;
            $display("FAIL %s rf_wdata: got %h required %h", name, rf_wdata, last_d);
        end
        checks++;
        if (busy !== 1'b1 || in_ready !== BYPASS) begin
            errors++;
            $display("FAIL %s commit busy/in_ready: got %b/%b required 1/%b", name, busy, in_ready, BYPASS);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after commit we/busy/ready: got %b/%b/%b required 0/0/1", name, rf_we, busy, in_ready);
        end
    endtask

    task automatic issue_nonload(input string name, input logic [1:0] sel, input logic [31:0] alu,
                                 input logic [31:0] pc4, input logic [31:0] imm, input logic [4:0] rd, input logic rw);
        logic [31:0] exp;
        wait_ready(name);
        in_result_sel = sel; in_alu_result = alu; in_pc_plus4 = pc4; in_imm = imm;
        in_rd = rd; in_reg_write = rw; in_funct3 = 3'($urandom);
        mem_rsp_valid = 1'($urandom); mem_rsp_data = $urandom;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_alu_result = $urandom; in_pc_plus4 = $urandom; in_imm = $urandom; in_rd = 5'($urandom);
        mem_rsp_valid = 1'($urandom);
        exp = sel == 2'b00 ? alu : sel == 2'b10 ? pc4 : imm;
        check_write(name, rw && rd != 0, rd, exp);
        mem_rsp_valid = 1'b0;
    endtask

    task automatic issue_load(input string name, input logic [2:0] f, input logic [31:0] addr,
                              input logic [31:0] data, input int wait_n, input logic [4:0] rd, input logic rw);
        wait_ready(name);
        in_result_sel = 2'b01; in_alu_result = addr; in_funct3 = f; in_rd = rd; in_reg_write = rw;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_alu_result = $urandom; in_funct3 = 3'($urandom); in_rd = 5'($urandom); in_reg_write = 1'($urandom);
        for (int i = 0; i < wait_n; i++) begin
            checks++;
            if (rf_we !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s waiting we/ready/busy: got %b/%b/%b required 0/0/1", name, rf_we, in_ready, busy);
            end
            tick();
        end
        mem_rsp_valid = 1'b1; mem_rsp_data = data;
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_data = $urandom;
        check_write(name, rw && rd != 0, rd, load_model(f, addr[1:0], data));
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset outputs: we=%b waddr=%0d wdata=%h required 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset busy/ready: got %b/%b required 0/1", busy, in_ready);
        end
        last_a = '0;
        last_d = '0;
    endtask

    task automatic test_alu;
        issue_nonload("alu_dir", 2'b00, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1'b1);
        for (int i = 0; i < 20; i++) begin
            logic [1:0] s;
            s = 2'($urandom);
            if (s == 2'b01) s = 2'b11;
            issue_nonload("alu_rand", s, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_x0;
        issue_nonload("x0_pc4", 2'b10, 32'h0, 32'h100, 32'h0, 5'd0, 1'b1);
        issue_nonload("no_rw", 2'b11, 32'h0, 32'h0, 32'hABCD_0000, 5'd9, 1'b0);
    endtask

    task automatic test_load;
        issue_load("lb_sign", 3'b000, 32'h0000_1002, 32'h1280_3344, 3, 5'd7, 1'b1);
        issue_load("lhu", 3'b101, 32'h0000_2002, 32'hBEEF_0000, 1, 5'd8, 1'b1);
        issue_load("lw_off3", 3'b010, 32'h0000_3003, 32'hDEAD_BEEF, 0, 5'd9, 1'b1);
        issue_load("lh_odd", 3'b001, 32'h0000_4001, 32'h1234_8765, 2, 5'd10, 1'b1);
        for (int i = 0; i < 24; i++)
            issue_load("load_rand", 3'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)),
                       5'($urandom), 1'($urandom));
    endtask

    task automatic test_reset_mid_load;
        wait_ready("rst_load");
        in_result_sel = 2'b01; in_alu_result = 32'h0; in_funct3 = 3'b010; in_rd = 5'd3; in_reg_write = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_a = '0;
        last_d = '0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_load after reset ready/busy/we: got %b/%b/%b required 1/0/0", in_ready, busy, rf_we);
        end
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_AAAA;
        tick();
        mem_rsp_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || busy !== 1'b0 || rf_wdata !== 32'd0) begin
            errors++;
            $display("FAIL rst_load stale rsp we/busy/wdata: got %b/%b/%h required 0/0/0", rf_we, busy, rf_wdata);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] vals[4];
        int          pc[$];
        logic [31:0] pd[$];
        int          idx = 0;
        bit          r;
        for (int k = 0; k < 4; k++) vals[k] = $urandom;
        wait_ready("b2b");
        in_result_sel = 2'b00; in_reg_write = 1'b1;
        in_alu_result = vals[0]; in_rd = 5'd1;
        in_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            r = in_ready;
            tick();
            if (rf_we === 1'b1) begin
                pc.push_back(c);
                pd.push_back(rf_wdata);
            end
            if (r && idx < 4) begin
                idx++;
                if (idx == 4) in_valid = 1'b0;
                else begin
                    in_alu_result = vals[idx];
                    in_rd = 5'(idx + 1);
                end
            end
        end
        checks++;
        if (pc.size() != 4) begin
            errors++;
            $display("FAIL b2b pulse count: got %0d required 4", pc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (pd[k] !== vals[k] || pc[k] != 1 + k * (BYPASS ? 1 : 2)) begin
                    errors++;
                    $display("FAIL b2b pulse %0d: cycle %0d data %h required cycle %0d data %h",
                             k, pc[k], pd[k], 1 + k * (BYPASS ? 1 : 2), vals[k]);
                end
            end
        end
        tick();
        tick();
        last_a = 5'd4;
        last_d = vals[3];
    endtask

    initial begin
        test_reset();
        test_alu();
        test_x0();
        test_load();
        test_reset_mid_load();
        test_back_to_back();
        test_alu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_result_stage.md
Name: wb_result_stage

Overview:
Write-back result stage. It sits at the register-file end of the datapath, downstream of the ALU operand muxes and the ALU.
- Accepts one retiring instruction per handshake.
- Selects the write-back source: ALU result, load data, PC+4 or immediate.
- For loads, waits for the data-memory response, then extracts and sign/zero-extends the addressed byte or halfword.
- Drives a single-cycle register-file write.

Parameters:
XLEN, 32, datapath width. Only 32 is supported.
REG_ADDR_W, 5, register index width.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  retiring instruction presented
in_ready  output  1  stage can accept; transfer occurs when in_valid && in_ready at a rising edge
in_result_sel  input  2  00=ALU, 01=memory load, 10=PC+4, 11=immediate
in_alu_result  input  32  ALU output; for loads, the byte address (bits [1:0] = offset)
in_pc_plus4  input  32  PC+4 of the instruction
in_imm  input  32  immediate (LUI)
in_funct3  input  3  load size/sign code
in_rd  input  5  destination register
in_reg_write  input  1  instruction writes rd
mem_rsp_valid  input  1  load data valid this cycle
mem_rsp_data  input  32  raw aligned word from data memory
rf_we  output  1  register-file write enable (one-cycle pulse)
rf_waddr  output  5  write address
rf_wdata  output  32  write data
busy  output  1  high whenever state != IDLE

Behaviour:
- States: IDLE, WAIT_MEM, COMMIT. All input fields are latched into internal registers on acceptance.
- IDLE:
  - in_ready=1.
  - On accept with sel==01, go to WAIT_MEM; on accept with any other sel, go to COMMIT.
  - No accept: remain in IDLE.
- WAIT_MEM:
  - in_ready=0.
  - On mem_rsp_valid, latch the extracted load value and go to COMMIT.
  - Otherwise wait indefinitely; there is no timeout.
- COMMIT:
  - rf_we = latched reg_write && latched rd != 0. Writes to x0 are suppressed.
  - rf_waddr = latched rd; rf_wdata = selected value.
  - Next state is IDLE.
- Outputs are driven from registered state only; no input-to-output combinational path except in_ready (see WB_BYPASS_EN).
- Latency:
  - Non-load: rf_we high exactly in the cycle after the accept edge.
  - Load: rf_we high in the cycle after the edge where mem_rsp_valid is sampled.
- Load extraction, with offset = alu_result[1:0]:
  - 000 LB: byte[offset], sign-extended.
  - 100 LBU: byte[offset], zero-extended.
  - 001 LH: half[offset[1]], sign-extended.
  - 101 LHU: half[offset[1]], zero-extended.
  - 010 and all other codes: full word; offset ignored.
  - offset[0] is ignored for halfwords; no misalignment trap.
- When rf_we=0, rf_waddr and rf_wdata hold their last values. The register file must ignore them.
- mem_rsp_valid outside WAIT_MEM is ignored and has no effect on state.
- A non-load instruction never waits for mem_rsp_valid.
- reset (any state, including mid-load):
  - state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, busy=0; in_ready=1 in the first cycle after reset.
  - The pending instruction is dropped.
  - A mem_rsp_valid arriving later for the dropped load is ignored.

Optional Feature:
WB_BYPASS_EN
- Defined:
  - in_ready is also 1 in COMMIT, so a new instruction can be accepted in the same cycle as the write.
  - Next state from COMMIT follows the IDLE accept rules; with no accept, go to IDLE.
  - Back-to-back non-loads sustain 1 instruction/cycle.
- Undefined:
  - in_ready is 1 only in IDLE.
  - Maximum throughput is one non-load per 2 cycles.

Test Plan:
1. ALU write: sel=00, alu=0x0000_1234, rd=5, reg_write=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x0000_1234; following cycle rf_we=0.
2. x0 suppression: sel=10, pc_plus4=0x100, rd=0, reg_write=1 -> no rf_we pulse; busy high for one cycle.
3. LB sign: sel=01, funct3=000, alu=0x...02; mem_rsp_valid after 3 cycles with data 0x1280_3344 -> rf_wdata=0xFFFF_FF80.
4. LHU: funct3=101, offset=2, data=0xBEEF_0000 -> 0x0000_BEEF. LW with offset=3 -> unchanged word.
5. Reset in WAIT_MEM: assert reset one cycle, then pulse mem_rsp_valid -> rf_we stays 0; in_ready=1 after reset.
6. Throughput: 4 back-to-back ALU instructions with in_valid held high -> 4 rf_we pulses in 4 consecutive cycles with WB_BYPASS_EN; alternating pulses over 8 cycles without it.
